// File: rtl/count_burst_sched_pkg.sv
// Shared types and defaults for the count burst scheduler.
package count_burst_sched_pkg;

  localparam int unsigned DEF_MOD  = 6;
  localparam int unsigned DEF_CNTW = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/count_burst_sched_en_delay_line.sv
// DELAY-stage enable shift register; collapses to a wire when DELAY is 0.
module count_burst_sched_en_delay_line #(
  parameter int unsigned DELAY = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic in_i,
  output logic out_o
);

  generate
    if (DELAY == 0) begin : g_wire
      assign out_o = in_i;
    end else begin : g_sr
      logic [DELAY-1:0] sr_q;
      logic [DELAY-1:0] sr_d;

      always_comb begin
        sr_d    = sr_q;
        sr_d[0] = in_i;
        for (int i = 1; i < int'(DELAY); i++) begin
          sr_d[i] = sr_q[i-1];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sr_q <= '0;
        end else begin
          sr_q <= sr_d;
        end
      end

      assign out_o = sr_q[DELAY-1];
    end
  endgenerate

endmodule

// File: rtl/count_burst_sched.sv
// Round-robin burst scheduler driving a shared mod-MOD enable counter,
// with a shadow copy of the count taken after the enable pipeline.
module count_burst_sched
  import count_burst_sched_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned LENW  = 4,
  parameter int unsigned MOD   = DEF_MOD,
  parameter int unsigned CNTW  = DEF_CNTW,
  parameter int unsigned DELAY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ*LENW-1:0] len_i,
  output logic [NREQ-1:0]      gnt_o,
  output logic [NREQ-1:0]      done_o,
  output logic                 busy_o,
  output logic                 en_o,
  output logic [CNTW-1:0]      count_o,
  output logic                 wrap_o
);

  localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned DLYW = ($clog2(DELAY + 1) > 0) ? $clog2(DELAY + 1) : 1;

  state_e            state_q, state_d;
  logic [IDXW-1:0]   rr_q, rr_d;
  logic [IDXW-1:0]   gidx_q, gidx_d;
  logic [LENW-1:0]   rem_q, rem_d;
  logic [DLYW-1:0]   dly_q, dly_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              busy_q, busy_d;
  logic              en_q, en_d;
  logic [CNTW-1:0]   count_q, count_d;
  logic              wrap_q, wrap_d;

  logic              pick_found;
  logic [IDXW-1:0]   pick_idx;
  logic [LENW-1:0]   pick_len;
  logic              en_dly;

  // First requester at or after the rr pointer, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int off = 0; off < int'(NREQ); off++) begin
      if (!pick_found && req_i[(int'(rr_q) + off) % int'(NREQ)]) begin
        pick_found = 1'b1;
        pick_idx   = IDXW'((int'(rr_q) + off) % int'(NREQ));
      end
    end
  end

  assign pick_len = len_i[int'(pick_idx)*int'(LENW) +: LENW];

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gidx_d  = gidx_q;
    rem_d   = rem_q;
    dly_d   = dly_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    en_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          gidx_d = pick_idx;
          gnt_d  = NREQ'(1) << pick_idx;
          rem_d  = pick_len;
          if (pick_len == '0) begin
            state_d = ST_DRAIN;
            dly_d   = DLYW'(DELAY);
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        en_d  = 1'b1;
        rem_d = rem_q - LENW'(1);
        if (rem_q == LENW'(1)) begin
          state_d = ST_DRAIN;
          dly_d   = DLYW'(DELAY);
        end
      end
      ST_DRAIN: begin
        // Last enable leaves en_o the cycle DRAIN starts; wait DELAY more.
        if (dly_q == '0) begin
          state_d = ST_DONE;
          done_d  = gnt_q;
        end else begin
          dly_d = dly_q - DLYW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        rr_d    = (gidx_q == IDXW'(NREQ - 1)) ? '0 : gidx_q + IDXW'(1);
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  count_burst_sched_en_delay_line #(
    .DELAY (DELAY)
  ) u_en_delay (
    .clk   (clk),
    .rst   (rst),
    .in_i  (en_q),
    .out_o (en_dly)
  );

  // Shadow counter steps on enables as they emerge from the pipeline.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (en_dly) begin
      if (count_q == CNTW'(MOD - 1)) begin
        count_d = '0;
        wrap_d  = 1'b1;
      end else begin
        count_d = count_q + CNTW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
      gidx_q  <= '0;
      rem_q   <= '0;
      dly_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gidx_q  <= gidx_d;
      rem_q   <= rem_d;
      dly_q   <= dly_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      en_q    <= en_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign gnt_o   = gnt_q;
  assign done_o  = done_q;
  assign busy_o  = busy_q;
  assign en_o    = en_q;
  assign count_o = count_q;
  assign wrap_o  = wrap_q;

endmodule

// File: tb/tb_count_burst_sched.sv
// Directed bench for count_burst_sched with a burst scoreboard and a count/rr model.
module tb_count_burst_sched;

  localparam int NREQ  = 4;
  localparam int LENW  = 4;
  localparam int MOD   = 6;
  localparam int CNTW  = 4;
  localparam int DELAY = 2;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req_i;
  logic [NREQ*LENW-1:0] len_i;
  logic [NREQ-1:0]      gnt_o;
  logic [NREQ-1:0]      done_o;
  logic                 busy_o;
  logic                 en_o;
  logic [CNTW-1:0]      count_o;
  logic                 wrap_o;

  count_burst_sched #(
    .NREQ  (NREQ),
    .LENW  (LENW),
    .MOD   (MOD),
    .CNTW  (CNTW),
    .DELAY (DELAY)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req_i   (req_i),
    .len_i   (len_i),
    .gnt_o   (gnt_o),
    .done_o  (done_o),
    .busy_o  (busy_o),
    .en_o    (en_o),
    .count_o (count_o),
    .wrap_o  (wrap_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NREQ-1:0] gnt;
    int              len;
    int              cnt;
    int              wraps;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_rr = 0;
  int   exp_count = 0;
  bit   range_bad = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] r, input int rr);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(rr + k) % NREQ]) return (rr + k) % NREQ;
    end
    return 0;
  endfunction

  // Drive a request at a negedge, then follow the granted burst to its done pulse.
  task automatic run_burst(input logic [NREQ-1:0] req, input logic [NREQ*LENW-1:0] lens,
                           input bit hold, input bit drop, output int wait_cyc);
    exp_t e;
    int   g;
    int   c;
    int   ens;
    int   wraps;
    bit   got;
    req_i = req;
    len_i = lens;
    g       = pick(req, exp_rr);
    e.gnt   = NREQ'(1) << g;
    e.len   = int'(lens[g*LENW +: LENW]);
    e.wraps = (exp_count + e.len) / MOD;
    exp_count = (exp_count + e.len) % MOD;
    e.cnt   = exp_count;
    sb.push_back(e);
    wait_cyc = 0;
    got = 1'b0;
    while (!got && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
      if (gnt_o != '0) got = 1'b1;
    end
    e = sb.pop_front();
    chk("grant_seen", 32'(got), 1);
    if (!got) return;
    chk("gnt_vec", 32'(gnt_o), 32'(e.gnt));
    if (drop) req_i = '0;
    c = 0;
    ens = 0;
    wraps = 0;
    got = 1'b0;
    while (!got && c < 40) begin
      @(negedge clk);
      c++;
      if (en_o) ens++;
      if (wrap_o) wraps++;
      if (int'(count_o) >= MOD) range_bad = 1'b1;
      if (done_o != '0) got = 1'b1;
    end
    chk("done_seen", 32'(got), 1);
    chk("done_latency", c, e.len + DELAY + 1);
    chk("done_vec", 32'(done_o), 32'(e.gnt));
    chk("gnt_held", 32'(gnt_o), 32'(e.gnt));
    chk("busy_at_done", 32'(busy_o), 1);
    chk("en_pulses", ens, e.len);
    chk("wraps", wraps, e.wraps);
    chk("count_at_done", 32'(count_o), e.cnt);
    exp_rr = (g + 1) % NREQ;
    if (!hold && !drop) req_i = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    req_i = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_rr    = 0;
    exp_count = 0;
    @(negedge clk);
  endtask

  initial begin
    int  w;
    int  ens;
    int  c;
    bit  got;
    bit  done_seen;
    rst   = 1'b1;
    req_i = '0;
    len_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_en", 32'(en_o), 0);
    chk("rst_count", 32'(count_o), 0);
    chk("rst_wrap", 32'(wrap_o), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single request, len 3.
    run_burst(4'b0001, 16'h0003, 1'b0, 1'b0, w);
    chk("grant_latency", w, 1);
    repeat (2) @(negedge clk);

    // Two len-4 bursts from requester 0 wrap the shadow count once.
    do_reset();
    run_burst(4'b0001, 16'h0004, 1'b0, 1'b0, w);
    run_burst(4'b0001, 16'h0004, 1'b0, 1'b0, w);

    // Round-robin with all requests held.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      run_burst(4'b1111, 16'h1111, 1'b1, 1'b0, w);
    end

    // Zero-length burst.
    run_burst(4'b0100, 16'h0000, 1'b0, 1'b0, w);
    repeat (2) @(negedge clk);

    // Reset in the middle of a len-8 burst after 3 enables.
    req_i = 4'b0010;
    len_i = 16'h0080;
    got = 1'b0;
    c = 0;
    while (!got && c < 20) begin
      @(negedge clk);
      c++;
      if (gnt_o != '0) got = 1'b1;
    end
    chk("mid_gnt", 32'(gnt_o), 32'(NREQ'(1) << pick(4'b0010, exp_rr)));
    ens = 0;
    c = 0;
    while (ens < 3 && c < 20) begin
      @(negedge clk);
      c++;
      if (en_o) ens++;
    end
    chk("mid_enables", ens, 3);
    rst   = 1'b1;
    req_i = '0;
    #1;
    chk("mid_rst_gnt", 32'(gnt_o), 0);
    chk("mid_rst_done", 32'(done_o), 0);
    chk("mid_rst_busy", 32'(busy_o), 0);
    chk("mid_rst_en", 32'(en_o), 0);
    chk("mid_rst_count", 32'(count_o), 0);
    chk("mid_rst_wrap", 32'(wrap_o), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_rr    = 0;
    exp_count = 0;
    done_seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done_o != '0) done_seen = 1'b1;
    end
    chk("no_done_after_rst", 32'(done_seen), 0);
    run_burst(4'b1111, 16'h1111, 1'b0, 1'b0, w);

    // Request dropped right after grant still completes a len-5 burst.
    repeat (2) @(negedge clk);
    run_burst(4'b0010, 16'h0050, 1'b0, 1'b1, w);

    chk("count_in_range", 32'(range_bad), 0);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
